// File: rtl/ltpi_pkg.sv
// ============================================================================
// Module  : ltpi_pkg
// Brief   : Shared link-training types, thresholds and frame-legality helper.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package ltpi_pkg;

   typedef enum logic [3:0] {
      ST_INIT                    = 4'd0,
      ST_COMMA_HUNTING           = 4'd1,
      ST_WAIT_LINK_DETECT_LOCKED = 4'd2,
      ST_WAIT_LINK_SPEED_LOCKED  = 4'd3,
      ST_ADVERTISE               = 4'd4,
      ST_WAIT_IN_ADVERTISE       = 4'd5,
      ST_CONFIGURATION_OR_ACCEPT = 4'd6,
      ST_OPERATIONAL             = 4'd7,
      ST_LINK_LOST               = 4'd8
   } rstate_t;

   typedef enum logic [2:0] {
      FRM_DEFAULT   = 3'd0,
      FRM_DATA      = 3'd1,
      FRM_DETECT    = 3'd2,
      FRM_SPEED     = 3'd3,
      FRM_ADVERTISE = 3'd4,
      FRM_CONFIGURE = 3'd5,
      FRM_ACCEPT    = 3'd6
   } frm_type_t;

   localparam int unsigned DETECT_LOCK_CNT_DEF = 7;
   localparam int unsigned TX_DETECT_CNT_DEF   = 255;
   localparam int unsigned TX_SPEED_CNT_DEF    = 7;
   localparam int unsigned CRC_LOSS_CNT_DEF    = 3;
   localparam int unsigned TIMER_1MS_60MHZ     = 60000;

   // States without a frame whitelist accept everything.
   function automatic logic frm_allowed(input rstate_t st, input frm_type_t ft);
      case (st)
         ST_WAIT_LINK_DETECT_LOCKED: return (ft == FRM_DETECT) || (ft == FRM_SPEED);
         ST_WAIT_LINK_SPEED_LOCKED:  return (ft == FRM_SPEED);
         ST_ADVERTISE,
         ST_WAIT_IN_ADVERTISE:       return (ft == FRM_ADVERTISE);
         ST_CONFIGURATION_OR_ACCEPT: return (ft == FRM_ADVERTISE) || (ft == FRM_ACCEPT);
         ST_OPERATIONAL:             return (ft == FRM_DEFAULT) || (ft == FRM_DATA);
         default:                    return 1'b1;
      endcase
   endfunction

endpackage

`default_nettype wire

// File: rtl/mgmt_consec_counter.sv
// ============================================================================
// Module  : mgmt_consec_counter
// Brief   : Saturating event counter with a sticky registered threshold flag.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mgmt_consec_counter #(
   parameter int unsigned WIDTH     = 4,
   parameter int unsigned THRESHOLD = 7
) (
   input  logic clk,
   input  logic reset,
   input  logic inc,
   input  logic clr_cnt,
   input  logic clr_all,
   output logic hit
);

   localparam logic [WIDTH-1:0] TH_W  = WIDTH'(THRESHOLD);
   localparam logic [WIDTH-1:0] MAX_W = '1;

   logic [WIDTH-1:0] count;
   logic [WIDTH-1:0] count_nxt;
   logic             hit_nxt;

   // clr_cnt restarts the run but keeps the flag; clr_all drops both.
   always_comb begin
      count_nxt = count;
      if (clr_all || clr_cnt) begin
         count_nxt = '0;
      end else if (inc && (count != MAX_W)) begin
         count_nxt = count + WIDTH'(1);
      end
      hit_nxt = (hit && !clr_all) || (count_nxt >= TH_W);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
         hit   <= 1'b0;
      end else begin
         count <= count_nxt;
         hit   <= hit_nxt;
      end
   end

endmodule

`default_nettype wire

// File: rtl/mgmt_phy_link_monitor.sv
// ============================================================================
// Module  : mgmt_phy_link_monitor
// Brief   : Watches link-training frames per state; flags lock, timeout, loss.
//           Optional MGMT_LINK_MONITOR_STATS_EN adds rx/crc statistics ports.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mgmt_phy_link_monitor
   import ltpi_pkg::*;
#(
   parameter int unsigned DETECT_LOCK_CNT = DETECT_LOCK_CNT_DEF,
   parameter int unsigned TX_DETECT_CNT   = TX_DETECT_CNT_DEF,
   parameter int unsigned TX_SPEED_CNT    = TX_SPEED_CNT_DEF,
   parameter int unsigned CRC_LOSS_CNT    = CRC_LOSS_CNT_DEF,
   parameter int unsigned SPEED_TIMEOUT   = TIMER_1MS_60MHZ
) (
   input  logic        clk,
   input  logic        reset,
   input  rstate_t     link_st,
   input  logic        rx_frm_valid,
   input  frm_type_t   rx_frm_type,
   input  logic        rx_crc_err,
   input  logic        tx_frm_done,
   input  frm_type_t   tx_frm_type,
   output logic        link_detect_locked,
   output logic        transmited_255_detect_frm,
   output logic        transmited_7_speed_frm,
   output logic        link_speed_timeout_detect,
   output logic        crc_consec_loss,
   output logic        unexpected_frame_error
`ifdef MGMT_LINK_MONITOR_STATS_EN
   ,
   output logic [15:0] rx_frm_cnt,
   output logic [15:0] crc_err_cnt
`endif
);

   localparam logic [15:0] TIMEOUT_W = 16'(SPEED_TIMEOUT);

   rstate_t     prev_st;
   logic [15:0] spd_timer;
   logic        spd_seen;

   // Events arriving in the same cycle as a state change belong to no state.
   logic entry, rx_ev, tx_ev, rx_good, rx_bad;
   logic in_det, in_spd, crc_mon, rx_good_speed;

   assign entry         = (link_st != prev_st);
   assign rx_ev         = rx_frm_valid && !entry;
   assign tx_ev         = tx_frm_done && !entry;
   assign rx_good       = rx_ev && !rx_crc_err;
   assign rx_bad        = rx_ev && rx_crc_err;
   assign in_det        = (link_st == ST_WAIT_LINK_DETECT_LOCKED);
   assign in_spd        = (link_st == ST_WAIT_LINK_SPEED_LOCKED);
   assign crc_mon       = (link_st != ST_INIT) && (link_st != ST_COMMA_HUNTING);
   assign rx_good_speed = rx_good && (rx_frm_type == FRM_SPEED);

   mgmt_consec_counter #(.WIDTH(4), .THRESHOLD(DETECT_LOCK_CNT)) u_det_lock (
      .clk     (clk),
      .reset   (reset),
      .inc     (in_det && rx_good && (rx_frm_type == FRM_DETECT)),
      .clr_cnt (in_det && rx_ev && (rx_crc_err || (rx_frm_type != FRM_DETECT))),
      .clr_all (entry),
      .hit     (link_detect_locked)
   );

   mgmt_consec_counter #(.WIDTH(8), .THRESHOLD(TX_DETECT_CNT)) u_tx_det (
      .clk     (clk),
      .reset   (reset),
      .inc     (in_det && tx_ev && (tx_frm_type == FRM_DETECT)),
      .clr_cnt (1'b0),
      .clr_all (entry),
      .hit     (transmited_255_detect_frm)
   );

   mgmt_consec_counter #(.WIDTH(4), .THRESHOLD(TX_SPEED_CNT)) u_tx_spd (
      .clk     (clk),
      .reset   (reset),
      .inc     (in_spd && tx_ev && (tx_frm_type == FRM_SPEED)),
      .clr_cnt (1'b0),
      .clr_all (entry),
      .hit     (transmited_7_speed_frm)
   );

   // Loss indication survives state changes; only a good frame or ST_INIT drops it.
   mgmt_consec_counter #(.WIDTH(4), .THRESHOLD(CRC_LOSS_CNT)) u_crc_loss (
      .clk     (clk),
      .reset   (reset),
      .inc     (crc_mon && rx_bad),
      .clr_cnt (entry),
      .clr_all ((entry && (link_st == ST_INIT)) || (crc_mon && rx_good)),
      .hit     (crc_consec_loss)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         prev_st                   <= ST_INIT;
         spd_timer                 <= '0;
         spd_seen                  <= 1'b0;
         link_speed_timeout_detect <= 1'b0;
         unexpected_frame_error    <= 1'b0;
      end else begin
         prev_st                <= link_st;
         unexpected_frame_error <= rx_good && !frm_allowed(link_st, rx_frm_type);
         if (entry) begin
            spd_timer                 <= '0;
            spd_seen                  <= 1'b0;
            link_speed_timeout_detect <= 1'b0;
         end else if (in_spd) begin
            if (rx_good_speed) begin
               spd_seen <= 1'b1;
            end else if (!spd_seen) begin
               if (spd_timer != 16'hFFFF) begin
                  spd_timer <= spd_timer + 16'd1;
               end
               if (spd_timer == TIMEOUT_W) begin
                  link_speed_timeout_detect <= 1'b1;
               end
            end
         end
      end
   end

`ifdef MGMT_LINK_MONITOR_STATS_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_frm_cnt  <= '0;
         crc_err_cnt <= '0;
      end else begin
         if (rx_frm_valid && (rx_frm_cnt != 16'hFFFF)) begin
            rx_frm_cnt <= rx_frm_cnt + 16'd1;
         end
         if (rx_frm_valid && rx_crc_err && (crc_err_cnt != 16'hFFFF)) begin
            crc_err_cnt <= crc_err_cnt + 16'd1;
         end
      end
   end
`else
   // Statistics counters are not built in this configuration.
`endif

endmodule

`default_nettype wire

// File: tb/tb_mgmt_phy_link_monitor.sv
// ============================================================================
// Module  : tb_mgmt_phy_link_monitor
// Brief   : Directed self-checking bench for mgmt_phy_link_monitor.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mgmt_phy_link_monitor;
   import ltpi_pkg::*;

   logic      clk = 1'b0;
   logic      reset = 1'b1;
   rstate_t   link_st = ST_INIT;
   logic      rx_frm_valid = 1'b0;
   frm_type_t rx_frm_type = FRM_DEFAULT;
   logic      rx_crc_err = 1'b0;
   logic      tx_frm_done = 1'b0;
   frm_type_t tx_frm_type = FRM_DEFAULT;
   logic      link_detect_locked, transmited_255_detect_frm, transmited_7_speed_frm;
   logic      link_speed_timeout_detect, crc_consec_loss, unexpected_frame_error;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mgmt_phy_link_monitor #(.SPEED_TIMEOUT(100)) dut (
      .clk                       (clk),
      .reset                     (reset),
      .link_st                   (link_st),
      .rx_frm_valid              (rx_frm_valid),
      .rx_frm_type               (rx_frm_type),
      .rx_crc_err                (rx_crc_err),
      .tx_frm_done               (tx_frm_done),
      .tx_frm_type               (tx_frm_type),
      .link_detect_locked        (link_detect_locked),
      .transmited_255_detect_frm (transmited_255_detect_frm),
      .transmited_7_speed_frm    (transmited_7_speed_frm),
      .link_speed_timeout_detect (link_speed_timeout_detect),
      .crc_consec_loss           (crc_consec_loss),
      .unexpected_frame_error    (unexpected_frame_error)
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_state(input rstate_t s);
      link_st = s;
      tick();
   endtask

   task automatic rx(input frm_type_t t, input logic crc);
      rx_frm_valid = 1'b1;
      rx_frm_type  = t;
      rx_crc_err   = crc;
      tick();
      rx_frm_valid = 1'b0;
      rx_crc_err   = 1'b0;
   endtask

   task automatic tx(input frm_type_t t);
      tx_frm_done = 1'b1;
      tx_frm_type = t;
      tick();
      tx_frm_done = 1'b0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, ".locked"},  16'(link_detect_locked), 16'd0);
      chk({tag, ".tx255"},   16'(transmited_255_detect_frm), 16'd0);
      chk({tag, ".tx7"},     16'(transmited_7_speed_frm), 16'd0);
      chk({tag, ".timeout"}, 16'(link_speed_timeout_detect), 16'd0);
      chk({tag, ".crcloss"}, 16'(crc_consec_loss), 16'd0);
      chk({tag, ".unexp"},   16'(unexpected_frame_error), 16'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      tick();
      tick();
      chk_all_zero("reset");
      reset = 1'b0;

      // Detect lock: seven consecutive good Detect frames
      set_state(ST_WAIT_LINK_DETECT_LOCKED);
      repeat (6) rx(FRM_DETECT, 1'b0);
      chk("lock_after6", 16'(link_detect_locked), 16'd0);
      rx(FRM_DETECT, 1'b0);
      chk("lock_after7", 16'(link_detect_locked), 16'd1);
      rx(FRM_DETECT, 1'b1);
      chk("lock_held", 16'(link_detect_locked), 16'd1);
      chk("crc_no_unexp", 16'(unexpected_frame_error), 16'd0);

      // Broken run: 6 good + CRC error + 6 good never locks
      set_state(ST_COMMA_HUNTING);
      chk("lock_cleared_exit", 16'(link_detect_locked), 16'd0);
      set_state(ST_WAIT_LINK_DETECT_LOCKED);
      repeat (6) rx(FRM_DETECT, 1'b0);
      rx(FRM_DETECT, 1'b1);
      repeat (6) rx(FRM_DETECT, 1'b0);
      chk("lock_broken_run", 16'(link_detect_locked), 16'd0);
      rx(FRM_DETECT, 1'b0);
      chk("lock_rerun7", 16'(link_detect_locked), 16'd1);

      // Tx Detect count, with rx and tx in the same cycle at the start
      set_state(ST_COMMA_HUNTING);
      set_state(ST_WAIT_LINK_DETECT_LOCKED);
      repeat (7) begin
         rx_frm_valid = 1'b1; rx_frm_type = FRM_DETECT; rx_crc_err = 1'b0;
         tx_frm_done  = 1'b1; tx_frm_type = FRM_DETECT;
         tick();
         rx_frm_valid = 1'b0; tx_frm_done = 1'b0;
      end
      chk("simul_lock", 16'(link_detect_locked), 16'd1);
      chk("simul_txcnt", 16'(dut.u_tx_det.count), 16'd7);
      repeat (247) tx(FRM_DETECT);
      chk("tx254", 16'(transmited_255_detect_frm), 16'd0);
      tx(FRM_DETECT);
      chk("tx255", 16'(transmited_255_detect_frm), 16'd1);
      repeat (45) tx(FRM_DETECT);
      chk("tx300_flag", 16'(transmited_255_detect_frm), 16'd1);
      chk("tx300_sat", 16'(dut.u_tx_det.count), 16'd255);

      // Speed state: tx Speed count and timeout with no Speed rx
      set_state(ST_WAIT_LINK_SPEED_LOCKED);
      chk("spd_entry_tx255", 16'(transmited_255_detect_frm), 16'd0);
      repeat (6) tx(FRM_SPEED);
      chk("txspd6", 16'(transmited_7_speed_frm), 16'd0);
      tx(FRM_SPEED);
      chk("txspd7", 16'(transmited_7_speed_frm), 16'd1);
      repeat (93) tick();
      chk("timeout_c100", 16'(link_speed_timeout_detect), 16'd0);
      tick();
      chk("timeout_c101", 16'(link_speed_timeout_detect), 16'd1);
      repeat (5) tick();
      chk("timeout_held", 16'(link_speed_timeout_detect), 16'd1);

      // Speed frame at cycle 50 stops the timer for the whole visit
      set_state(ST_ADVERTISE);
      chk("timeout_exit", 16'(link_speed_timeout_detect), 16'd0);
      set_state(ST_WAIT_LINK_SPEED_LOCKED);
      repeat (49) tick();
      rx(FRM_SPEED, 1'b0);
      chk("speed_allowed", 16'(unexpected_frame_error), 16'd0);
      repeat (150) tick();
      chk("timeout_stopped", 16'(link_speed_timeout_detect), 16'd0);

      // Operational: consecutive CRC loss
      set_state(ST_OPERATIONAL);
      rx(FRM_DATA, 1'b1);
      rx(FRM_DATA, 1'b1);
      chk("crc2", 16'(crc_consec_loss), 16'd0);
      rx(FRM_DATA, 1'b1);
      chk("crc3", 16'(crc_consec_loss), 16'd1);
      rx(FRM_DATA, 1'b0);
      chk("crc_good_clr", 16'(crc_consec_loss), 16'd0);
      chk("data_allowed", 16'(unexpected_frame_error), 16'd0);
      rx(FRM_DATA, 1'b1);
      rx(FRM_DATA, 1'b1);
      rx(FRM_DATA, 1'b0);
      rx(FRM_DATA, 1'b1);
      chk("crc2_good_1", 16'(crc_consec_loss), 16'd0);
      rx(FRM_DATA, 1'b1);
      rx(FRM_DATA, 1'b1);
      repeat (14) rx(FRM_DATA, 1'b1);
      chk("crc_saturated", 16'(crc_consec_loss), 16'd1);
      chk("crc_sat_count", 16'(dut.u_crc_loss.count), 16'd15);
      set_state(ST_INIT);
      chk("crc_init_clr", 16'(crc_consec_loss), 16'd0);

      // Configuration: unexpected frame pulse only for CRC-good frames
      set_state(ST_CONFIGURATION_OR_ACCEPT);
      rx(FRM_DETECT, 1'b0);
      chk("unexp_pulse", 16'(unexpected_frame_error), 16'd1);
      tick();
      chk("unexp_one_cycle", 16'(unexpected_frame_error), 16'd0);
      rx(FRM_DETECT, 1'b1);
      chk("unexp_crc_none", 16'(unexpected_frame_error), 16'd0);
      rx(FRM_ACCEPT, 1'b0);
      chk("accept_allowed", 16'(unexpected_frame_error), 16'd0);

      // Events coinciding with a state change are discarded
      link_st = ST_OPERATIONAL;
      rx_frm_valid = 1'b1; rx_frm_type = FRM_DETECT; rx_crc_err = 1'b0;
      tick();
      rx_frm_valid = 1'b0;
      chk("entry_rx_no_unexp", 16'(unexpected_frame_error), 16'd0);
      link_st = ST_WAIT_LINK_DETECT_LOCKED;
      rx_frm_valid = 1'b1; rx_frm_type = FRM_DETECT;
      tick();
      rx_frm_valid = 1'b0;
      chk("entry_rx_cnt0", 16'(dut.u_det_lock.count), 16'd0);
      repeat (6) rx(FRM_DETECT, 1'b0);
      chk("entry_lock6", 16'(link_detect_locked), 16'd0);
      rx(FRM_DETECT, 1'b0);
      chk("entry_lock7", 16'(link_detect_locked), 16'd1);

      // Reset mid-count clears everything on the next edge
      tx(FRM_DETECT);
      reset = 1'b1;
      tick();
      chk_all_zero("midreset");
      chk("midreset_txcnt", 16'(dut.u_tx_det.count), 16'd0);
      reset = 1'b0;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
